wb2uart: RTL and testbench
==========================

Name: wb2uart

Overview:
- Wishbone slave that tunnels each bus access over a UART link to the remote UART-to-Wishbone bridge. This block is the initiator end of that link.
- Serialises every request into a 4-byte command frame on uart_txd, then waits for the 1-byte response on uart_rxd and completes the bus cycle with it.
- Used for chip-to-chip access and for FPGA/bench host models of the bridge.

Parameters:
- CLKS_PER_BIT, 16: clk_i cycles per UART bit. Must match the bridge.
- TIMEOUT_CYCLES, 65535: cycles allowed from end of command to the response start bit. 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cyc_i  in  1  Wishbone cycle
- stb_i  in  1  Wishbone strobe
- we_i  in  1  write enable
- adr_i  in  23  byte address
- dat_i  in  8  write data
- ack_o  out  1  normal completion, one-cycle pulse
- err_o  out  1  error completion (framing or timeout), one-cycle pulse
- dat_o  out  8  read data / response byte
- uart_txd  out  1  serial out, idles high
- uart_rxd  in  1  serial in, asynchronous

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. On rst_ni low, immediately and regardless of state:
  - uart_txd=1, ack_o=0, err_o=0, dat_o=0x00, FSM=IDLE, all counters 0.
  - uart_rxd passes through a 2-flop synchroniser; the synchroniser resets to 1.
- UART format: 8N1, LSB first, CLKS_PER_BIT cycles per bit, no inter-byte gap.
- Command frame bytes, in order:
  - byte0 = {we_i, adr_i[22:16]}
  - byte1 = adr_i[15:8]
  - byte2 = adr_i[7:0]
  - byte3 = dat_i (read: 0x00)
- Response: one byte. Write responses carry 0x00; read responses carry the read data.
- FSM states:
  - IDLE: on cyc_i&stb_i, latch we/adr/dat into a 32-bit shift register; next cycle uart_txd=0 (TX_START).
  - TX_START, TX_DATA(8 bits), TX_STOP: each bit lasts exactly CLKS_PER_BIT cycles. After byte3's stop bit, go to RX_WAIT; else start the next byte. A frame is exactly 40*CLKS_PER_BIT cycles.
  - RX_WAIT: wait for synchronised rxd falling edge. Any rxd activity before entering RX_WAIT is ignored. Timeout counter runs here; on expiry pulse err_o, dat_o unchanged, go to IDLE.
  - RX_START: wait CLKS_PER_BIT/2 cycles. If rxd is high there, treat it as a glitch and return to RX_WAIT. The timeout counter is not reset.
  - RX_DATA: sample 8 bits at CLKS_PER_BIT intervals from the start-bit midpoint.
  - RX_STOP: sample the stop bit.
    - High: dat_o <= byte, then pulse ack_o for exactly 1 cycle in the following cycle.
    - Low: pulse err_o, leave dat_o unchanged.
    - In both cases go to IDLE.
- dat_o holds its value until the next successful response.
- Bus abort: if cyc_i drops mid-transaction, the frame still completes and the response is received (or times out). ack_o/err_o are suppressed; the response is discarded. This keeps the bridge's byte counter aligned.
- Requests are accepted only in IDLE. cyc_i&stb_i in other states is held off, with no ack.
- A new request can start the cycle after an ack/err pulse if cyc_i&stb_i remain asserted.
- Reset mid-frame truncates the command and desynchronises the remote bridge. System reset must reset both ends together; no recovery here.
- Counters: bit-timer width is clog2(CLKS_PER_BIT); timeout counter width is clog2(TIMEOUT_CYCLES+1). Neither may wrap silently.

Test Plan:
- Write adr=0x012345, dat=0xA5 -> txd bytes 0x81,0x23,0x45,0xA5 (LSB first, 160 clk/byte, 640 clk frame); bridge model replies 0x00 -> single ack_o, dat_o=0x00, err_o=0.
- Read adr=0x7FFFFF -> bytes 0x7F,0xFF,0xFF,0x00; model replies 0x3C after 200 idle clocks -> ack_o one cycle after stop-bit sample, dat_o=0x3C held through next IDLE.
- Read, model replies 0x55 with stop bit driven low -> err_o one pulse, no ack, dat_o keeps prior 0x3C; next request proceeds normally.
- Read with TIMEOUT_CYCLES=100 and no reply -> err_o exactly 100 cycles after byte3 stop bit ends; a 4-cycle low glitch on rxd during the wait is ignored.
- Deassert cyc_i during byte1 -> all 4 bytes still sent, reply consumed, no ack/err; a following write completes normally.
- Assert rst_ni=0 during TX_DATA of byte2 -> uart_txd=1 in the same cycle (asynchronous), outputs at reset values, FSM in IDLE after release.

Source files
------------

// File: rtl/wb2uart_if.sv
// Wishbone classic bus bundle for the wb2uart tunnel (slave side = wb2uart).
interface wb2uart_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [22:0] adr_i;
    logic [7:0]  dat_i;
    logic        ack_o;
    logic        err_o;
    logic [7:0]  dat_o;

    modport slave  (input  cyc_i, stb_i, we_i, adr_i, dat_i,
                    output ack_o, err_o, dat_o);
    modport master (output cyc_i, stb_i, we_i, adr_i, dat_i,
                    input  ack_o, err_o, dat_o);
endinterface

// File: rtl/wb2uart.sv
// Wishbone slave that forwards each access as a 4-byte UART command frame and
// completes the bus cycle with the 1-byte response from the remote bridge.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | waiting for cyc_i & stb_i, frame latched on accept
// TX_START | driving start bit of current command byte
// TX_DATA  | driving 8 data bits, LSB first
// TX_STOP  | driving stop bit, then next byte or RX_WAIT after byte3
// RX_WAIT  | waiting for response start edge, timeout running
// RX_START | confirming start bit at its midpoint (glitch -> RX_WAIT)
// RX_DATA  | sampling 8 response bits at bit centres
// RX_STOP  | sampling stop bit: high -> RESP, low -> framing error
// RESP     | one cycle after the data update, ack_o is raised here
module wb2uart #(
    parameter int CLKS_PER_BIT   = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    wb2uart_if.slave wb,
    output logic     uart_txd,
    input  logic     uart_rxd
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int OW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'((CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0);
    localparam logic [OW-1:0] TO_LOAD   = OW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [3:0] {
        IDLE, TX_START, TX_DATA, TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_STOP, RESP
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [OW-1:0] to_cnt_q, to_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   shreg_q, shreg_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic [7:0]    dat_q, dat_d;
    logic          txd_q, txd_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          abort_q, abort_d;
    logic          rx_s1_q, rx_s1_d;
    logic          rx_s2_q, rx_s2_d;
    logic          rx_prev_q, rx_prev_d;

    logic timer_zero;
    logic timed_out;
    logic keep;

    assign timer_zero = (timer_q == '0);
    assign timed_out  = (TIMEOUT_CYCLES != 0) && (to_cnt_q == '0);
    // Completion is reported only if the master has stayed in its cycle throughout.
    assign keep       = wb.cyc_i && !abort_q;

    assign uart_txd  = txd_q;
    assign wb.ack_o  = ack_q;
    assign wb.err_o  = err_q;
    assign wb.dat_o  = dat_q;

    // Next-state logic for the serialiser, deserialiser and bus handshake.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        to_cnt_d   = to_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        rx_byte_d  = rx_byte_q;
        dat_d      = dat_q;
        txd_d      = txd_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        abort_d    = abort_q;
        rx_s1_d    = uart_rxd;
        rx_s2_d    = rx_s1_q;
        rx_prev_d  = rx_s2_q;

        if (state_q != IDLE && !wb.cyc_i) abort_d = 1'b1;
        if (!timer_zero) timer_d = timer_q - 1'b1;
        if ((state_q == RX_WAIT || state_q == RX_START) && to_cnt_q != '0)
            to_cnt_d = to_cnt_q - 1'b1;

        case (state_q)
            IDLE: begin
                // Holding off while ack/err is up keeps a classic master that
                // drops stb on seeing ack from launching a duplicate request.
                if (wb.cyc_i && wb.stb_i && !ack_q && !err_q) begin
                    shreg_d    = {wb.we_i, wb.adr_i, wb.we_i ? wb.dat_i : 8'h00};
                    state_d    = TX_START;
                    txd_d      = 1'b0;
                    timer_d    = BIT_LOAD;
                    byte_cnt_d = 2'd0;
                    abort_d    = 1'b0;
                end
            end
            TX_START: begin
                if (timer_zero) begin
                    state_d         = TX_DATA;
                    txd_d           = shreg_q[24];
                    shreg_d[31:24]  = {1'b0, shreg_q[31:25]};
                    bit_cnt_d       = 3'd0;
                    timer_d         = BIT_LOAD;
                end
            end
            TX_DATA: begin
                if (timer_zero) begin
                    timer_d = BIT_LOAD;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = TX_STOP;
                        txd_d   = 1'b1;
                        shreg_d = {shreg_q[23:0], 8'h00};
                    end else begin
                        txd_d          = shreg_q[24];
                        shreg_d[31:24] = {1'b0, shreg_q[31:25]};
                        bit_cnt_d      = bit_cnt_q + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (timer_zero) begin
                    if (byte_cnt_q == 2'd3) begin
                        state_d  = RX_WAIT;
                        to_cnt_d = TO_LOAD;
                    end else begin
                        state_d    = TX_START;
                        txd_d      = 1'b0;
                        timer_d    = BIT_LOAD;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            RX_WAIT: begin
                if (timed_out) begin
                    err_d   = keep;
                    state_d = IDLE;
                end else if (!rx_s2_q && rx_prev_q) begin
                    state_d = RX_START;
                    timer_d = HALF_LOAD;
                end
            end
            RX_START: begin
                if (timed_out) begin
                    err_d   = keep;
                    state_d = IDLE;
                end else if (timer_zero) begin
                    if (rx_s2_q) begin
                        state_d = RX_WAIT;
                    end else begin
                        state_d   = RX_DATA;
                        timer_d   = BIT_LOAD;
                        bit_cnt_d = 3'd0;
                    end
                end
            end
            RX_DATA: begin
                if (timer_zero) begin
                    rx_byte_d = {rx_s2_q, rx_byte_q[7:1]};
                    timer_d   = BIT_LOAD;
                    if (bit_cnt_q == 3'd7) state_d = RX_STOP;
                    else                   bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (timer_zero) begin
                    if (rx_s2_q) begin
                        if (keep) dat_d = rx_byte_q;
                        state_d = RESP;
                    end else begin
                        err_d   = keep;
                        state_d = IDLE;
                    end
                end
            end
            RESP: begin
                ack_d   = keep;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; the rxd synchroniser idles high in reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            to_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
            rx_byte_q  <= '0;
            dat_q      <= '0;
            txd_q      <= 1'b1;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            to_cnt_q   <= to_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            rx_byte_q  <= rx_byte_d;
            dat_q      <= dat_d;
            txd_q      <= txd_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_prev_q  <= rx_prev_d;
        end
    end
endmodule

// File: tb/tb_wb2uart.sv
// Directed bench for wb2uart: decodes the command frame on uart_txd, plays the
// remote bridge on uart_rxd and checks the bus completion of each access.
module tb_wb2uart;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd   = 1'b1;
    logic rxd2  = 1'b1;
    wire  txd;
    wire  txd2;
    logic mon_sel = 1'b0;
    wire  txd_mon = mon_sel ? txd2 : txd;

    wb2uart_if bus ();
    wb2uart_if bus2 ();

    wb2uart #(.CLKS_PER_BIT(16), .TIMEOUT_CYCLES(65535)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .wb(bus), .uart_txd(txd), .uart_rxd(rxd));

    wb2uart #(.CLKS_PER_BIT(16), .TIMEOUT_CYCLES(100)) u_dut_to (
        .clk_i(clk), .rst_ni(rst_n), .wb(bus2), .uart_txd(txd2), .uart_rxd(rxd2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int req_cyc  = 0;
    int send_cyc = 0;

    int ack_n = 0, err_n = 0, ack2_n = 0, err2_n = 0;
    int ack_cyc = 0, err2_cyc = 0, dat_cyc = 0;
    logic [7:0] dat_prev = 8'h00;

    // Completion monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.ack_o === 1'b1) begin ack_n++; ack_cyc = cyc; end
        if (bus.err_o === 1'b1) err_n++;
        if (bus2.ack_o === 1'b1) ack2_n++;
        if (bus2.err_o === 1'b1) begin err2_n++; err2_cyc = cyc; end
        if (bus.dat_o !== dat_prev) begin dat_cyc = cyc; dat_prev = bus.dat_o; end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit sel, input bit we, input logic [22:0] adr, input logic [7:0] dat);
        @(posedge clk); #1;
        req_cyc = cyc;
        if (sel) begin
            bus2.cyc_i = 1'b1; bus2.stb_i = 1'b1; bus2.we_i = we; bus2.adr_i = adr; bus2.dat_i = dat;
        end else begin
            bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we; bus.adr_i = adr; bus.dat_i = dat;
        end
    endtask

    task automatic drop_req(input bit sel);
        if (sel) begin bus2.cyc_i = 1'b0; bus2.stb_i = 1'b0; end
        else begin bus.cyc_i = 1'b0; bus.stb_i = 1'b0; end
    endtask

    // Decodes nbytes command bytes; returns at the stop-bit centre of the last one.
    task automatic capture_frame(input bit sel, input logic [31:0] exp, input int abort_byte,
                                 input int nbytes, output int start0);
        int st;
        bit found;
        logic [7:0] b;
        mon_sel = sel;
        start0 = 0;
        for (int k = 0; k < nbytes; k++) begin
            found = 1'b0;
            for (int w = 0; w < 3000 && !found; w++) begin
                @(negedge clk);
                if (txd_mon === 1'b0) found = 1'b1;
            end
            if (!found) begin
                check($sformatf("byte%0d_start_seen", k), 32'd0, 32'd1);
                return;
            end
            st = cyc;
            if (k == 0) start0 = st;
            else check($sformatf("byte%0d_start_cycle", k), 32'(st - start0), 32'(160 * k));
            if (k == abort_byte) drop_req(sel);
            repeat (8) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (16) @(negedge clk);
                b[i] = txd_mon;
            end
            repeat (16) @(negedge clk);
            check($sformatf("byte%0d_stop", k), 32'(txd_mon), 32'd1);
            check($sformatf("byte%0d_value", k), 32'(b), 32'(exp[31 - 8 * k -: 8]));
        end
    endtask

    task automatic uart_send(input bit sel, input logic [7:0] b, input bit stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        @(posedge clk); #1;
        send_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            if (sel) rxd2 = fr[i]; else rxd = fr[i];
            repeat (16) @(posedge clk);
            #1;
        end
        if (sel) rxd2 = 1'b1; else rxd = 1'b1;
    endtask

    task automatic wait_resp(input bit sel, input int budget, output bit got);
        got = 1'b0;
        for (int w = 0; w < budget && !got; w++) begin
            @(negedge clk);
            if (sel ? (bus2.ack_o | bus2.err_o) : (bus.ack_o | bus.err_o)) got = 1'b1;
        end
        drop_req(sel);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d required below limit", cyc);
        $fatal(1);
    end

    initial begin
        int s0;
        int lows;
        bit got;
        bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; bus.adr_i = '0; bus.dat_i = '0;
        bus2.cyc_i = 0; bus2.stb_i = 0; bus2.we_i = 0; bus2.adr_i = '0; bus2.dat_i = '0;

        repeat (3) @(posedge clk); #1;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_ack", 32'(bus.ack_o), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check("rst_dat", 32'(bus.dat_o), 32'h00);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Write 0x012345 <- 0xA5
        set_req(0, 1'b1, 23'h012345, 8'hA5);
        capture_frame(0, 32'h812345A5, -1, 4, s0);
        check("t1_start_latency", 32'(s0 - req_cyc), 32'd1);
        repeat (8) @(negedge clk);
        fork
            uart_send(0, 8'h00, 1'b1);
            wait_resp(0, 400, got);
        join
        repeat (5) @(negedge clk);
        check("t1_got", 32'(got), 32'd1);
        check("t1_ack_n", 32'(ack_n), 32'd1);
        check("t1_err_n", 32'(err_n), 32'd0);
        check("t1_dat", 32'(bus.dat_o), 32'h00);

        // Read 0x7FFFFF, reply 0x3C after 200 idle clocks
        set_req(0, 1'b0, 23'h7FFFFF, 8'hEE);
        capture_frame(0, 32'h7FFFFF00, -1, 4, s0);
        repeat (8) @(negedge clk);
        repeat (200) @(posedge clk);
        fork
            uart_send(0, 8'h3C, 1'b1);
            wait_resp(0, 400, got);
        join
        repeat (5) @(negedge clk);
        check("t2_ack_n", 32'(ack_n), 32'd2);
        check("t2_err_n", 32'(err_n), 32'd0);
        check("t2_dat", 32'(bus.dat_o), 32'h3C);
        check("t2_ack_after_data", 32'(ack_cyc - dat_cyc), 32'd1);
        check("t2_ack_window", 32'((ack_cyc > send_cyc + 152) && (ack_cyc < send_cyc + 164)), 32'd1);
        repeat (50) @(negedge clk);
        check("t2_dat_held", 32'(bus.dat_o), 32'h3C);

        // Read with framing error on the reply
        set_req(0, 1'b0, 23'h000010, 8'h00);
        capture_frame(0, 32'h00001000, -1, 4, s0);
        repeat (8) @(negedge clk);
        fork
            uart_send(0, 8'h55, 1'b0);
            wait_resp(0, 400, got);
        join
        repeat (5) @(negedge clk);
        check("t3_err_n", 32'(err_n), 32'd1);
        check("t3_ack_n", 32'(ack_n), 32'd2);
        check("t3_dat_kept", 32'(bus.dat_o), 32'h3C);

        set_req(0, 1'b0, 23'h000001, 8'h00);
        capture_frame(0, 32'h00000100, -1, 4, s0);
        repeat (8) @(negedge clk);
        fork
            uart_send(0, 8'h5A, 1'b1);
            wait_resp(0, 400, got);
        join
        repeat (5) @(negedge clk);
        check("t3b_ack_n", 32'(ack_n), 32'd3);
        check("t3b_dat", 32'(bus.dat_o), 32'h5A);

        // Bus abort during byte1: frame completes, reply swallowed silently
        set_req(0, 1'b1, 23'h00ABCD, 8'h11);
        capture_frame(0, 32'h80ABCD11, 1, 4, s0);
        repeat (8) @(negedge clk);
        fork
            uart_send(0, 8'h99, 1'b1);
            wait_resp(0, 300, got);
        join
        check("t5_no_resp", 32'(got), 32'd0);
        check("t5_ack_n", 32'(ack_n), 32'd3);
        check("t5_err_n", 32'(err_n), 32'd1);
        check("t5_dat_kept", 32'(bus.dat_o), 32'h5A);

        set_req(0, 1'b0, 23'h000002, 8'h00);
        capture_frame(0, 32'h00000200, -1, 4, s0);
        repeat (8) @(negedge clk);
        fork
            uart_send(0, 8'hC3, 1'b1);
            wait_resp(0, 400, got);
        join
        repeat (5) @(negedge clk);
        check("t5b_ack_n", 32'(ack_n), 32'd4);
        check("t5b_dat", 32'(bus.dat_o), 32'hC3);

        // Timeout of 100 cycles with a 4-cycle glitch in the wait window
        set_req(1, 1'b0, 23'h000003, 8'h00);
        capture_frame(1, 32'h00000300, -1, 4, s0);
        while (cyc < s0 + 660) @(posedge clk);
        #1 rxd2 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd2 = 1'b1;
        wait_resp(1, 300, got);
        repeat (3) @(negedge clk);
        check("t4_got", 32'(got), 32'd1);
        check("t4_err_n", 32'(err2_n), 32'd1);
        check("t4_ack_n", 32'(ack2_n), 32'd0);
        check("t4_err_cycle", 32'(err2_cyc - s0), 32'd740);
        check("t4_dat", 32'(bus2.dat_o), 32'h00);

        // Asynchronous reset during byte2 data bits (all zero, so txd is low)
        set_req(0, 1'b1, 23'h123400, 8'h66);
        capture_frame(0, 32'h92340066, -1, 2, s0);
        while (cyc < s0 + 400) @(posedge clk);
        #3;
        check("t6_txd_before", 32'(txd), 32'd0);
        rst_n = 1'b0;
        drop_req(0);
        #1;
        check("t6_txd_async", 32'(txd), 32'd1);
        check("t6_ack", 32'(bus.ack_o), 32'd0);
        check("t6_err", 32'(bus.err_o), 32'd0);
        check("t6_dat", 32'(bus.dat_o), 32'h00);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check("t6_idle_after_release", 32'(lows), 32'd0);

        set_req(0, 1'b0, 23'h000004, 8'h00);
        capture_frame(0, 32'h00000400, -1, 4, s0);
        check("t7_start_latency", 32'(s0 - req_cyc), 32'd1);
        repeat (8) @(negedge clk);
        fork
            uart_send(0, 8'h42, 1'b1);
            wait_resp(0, 400, got);
        join
        repeat (5) @(negedge clk);
        check("t7_ack_n", 32'(ack_n), 32'd5);
        check("t7_dat", 32'(bus.dat_o), 32'h42);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
